// File: rtl/pe_result_collector_pkg.sv
// Shared sizing and state encodings for the single-PE result collector.
package pe_result_collector_pkg;

    localparam int DATA_W    = 8;
    localparam int OUT_ROWS  = 2;
    localparam int OUT_COLS  = 2;
    localparam int N_RESULTS = OUT_ROWS * OUT_COLS;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/pe_result_collector.sv
// Assembles the PE result stream into a 2x2 frame with running max and
// presents it downstream with a valid/ack handshake.
module pe_result_collector
    import pe_result_collector_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en_result,
    input  logic [DATA_W-1:0] acc_in,
    input  logic              pe_done,
    input  logic              result_ack,
    output logic [DATA_W-1:0] c_1_1,
    output logic [DATA_W-1:0] c_1_2,
    output logic [DATA_W-1:0] c_2_1,
    output logic [DATA_W-1:0] c_2_2,
    output logic [DATA_W-1:0] max_out,
    output logic              result_valid,
    output logic              err_short,
    output logic              err_overflow
);

    localparam int IDX_W = $clog2(N_RESULTS);

    state_e                             state_q, state_d;
    logic [CNT_W-1:0]                   count_q, count_d;
    logic [N_RESULTS-1:0][DATA_W-1:0]   slot_q, slot_d;
    logic [DATA_W-1:0]                  max_q, max_d;
    logic                               valid_q, valid_d;
    logic                               err_short_q, err_short_d;
    logic                               err_ovf_q, err_ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            slot_q      <= '0;
            max_q       <= '0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            slot_q      <= slot_d;
            max_q       <= max_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        slot_d      = slot_q;
        max_d       = max_q;
        valid_d     = valid_q;
        err_short_d = err_short_q;
        err_ovf_d   = err_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (en_result) begin
                    slot_d      = '0;
                    slot_d[0]   = acc_in;
                    max_d       = acc_in;
                    err_short_d = 1'b0;
                    err_ovf_d   = 1'b0;
                    count_d     = CNT_W'(1);
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (en_result) begin
                    slot_d[count_q[IDX_W-1:0]] = acc_in;
                    if (acc_in > max_q) max_d = acc_in;
                    count_d = count_q + CNT_W'(1);
                end
                // Completeness is judged after this cycle's write, so the last
                // strobe arriving with pe_done still yields a clean frame.
                if (count_d == CNT_W'(N_RESULTS)) begin
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (pe_done) begin
                    err_short_d = 1'b1;
                    valid_d     = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (en_result) err_ovf_d = 1'b1;
                if (result_ack) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign c_1_1        = slot_q[0];
    assign c_1_2        = slot_q[1];
    assign c_2_1        = slot_q[2];
    assign c_2_2        = slot_q[3];
    assign max_out      = max_q;
    assign result_valid = valid_q;
    assign err_short    = err_short_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// Table-driven bench for pe_result_collector with a queue-based scoreboard.
module tb_pe_result_collector;

    logic       clk = 1'b0;
    logic       reset, en_result, pe_done, result_ack;
    logic [7:0] acc_in;
    logic [7:0] c_1_1, c_1_2, c_2_1, c_2_2, max_out;
    logic       result_valid, err_short, err_overflow;

    int errors = 0;
    int checks = 0;

    pe_result_collector dut (
        .clk(clk), .reset(reset), .en_result(en_result), .acc_in(acc_in),
        .pe_done(pe_done), .result_ack(result_ack),
        .c_1_1(c_1_1), .c_1_2(c_1_2), .c_2_1(c_2_1), .c_2_2(c_2_2),
        .max_out(max_out), .result_valid(result_valid),
        .err_short(err_short), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, done, ack;
        logic [7:0] acc;
        logic       v, es, eo;
        logic [7:0] c11, c12, c21, c22, mx;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    logic [7:0] data_q[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic [7:0] acc,
                                input logic done, input logic ack,
                                input logic v, input logic es, input logic eo,
                                input logic [7:0] c11, input logic [7:0] c12,
                                input logic [7:0] c21, input logic [7:0] c22,
                                input logic [7:0] mx);
        vec_t r;
        r.rst = rst; r.en = en; r.acc = acc; r.done = done; r.ack = ack;
        r.v = v; r.es = es; r.eo = eo;
        r.c11 = c11; r.c12 = c12; r.c21 = c21; r.c22 = c22; r.mx = mx;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".valid"}, {7'd0, result_valid}, {7'd0, e.v});
        chk({tag, ".err_short"}, {7'd0, err_short}, {7'd0, e.es});
        chk({tag, ".err_overflow"}, {7'd0, err_overflow}, {7'd0, e.eo});
        chk({tag, ".c_1_1"}, c_1_1, e.c11);
        chk({tag, ".c_1_2"}, c_1_2, e.c12);
        chk({tag, ".c_2_1"}, c_2_1, e.c21);
        chk({tag, ".c_2_2"}, c_2_2, e.c22);
        chk({tag, ".max_out"}, max_out, e.mx);
    endtask

    initial begin
        vec_t e;
        logic [7:0] mx;
        int n;
        reset = 1'b1; en_result = 1'b0; pe_done = 1'b0; result_ack = 1'b0; acc_in = '0;

        //            rst en acc   dn ak  v es eo  c11   c12   c21   c22   max
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        // clean back-to-back frame; pe_done in HOLD ignored, then ack
        tbl.push_back(mk(0, 1, 8'd5,  0, 0, 0, 0, 0, 8'd5,  8'd0,  8'd0,  8'd0,  8'd5));
        tbl.push_back(mk(0, 1, 8'd9,  0, 0, 0, 0, 0, 8'd5,  8'd9,  8'd0,  8'd0,  8'd9));
        tbl.push_back(mk(0, 1, 8'd3,  0, 0, 0, 0, 0, 8'd5,  8'd9,  8'd3,  8'd0,  8'd9));
        tbl.push_back(mk(0, 1, 8'd7,  0, 0, 1, 0, 0, 8'd5,  8'd9,  8'd3,  8'd7,  8'd9));
        tbl.push_back(mk(0, 0, 8'd0,  1, 0, 1, 0, 0, 8'd5,  8'd9,  8'd3,  8'd7,  8'd9));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 0, 0, 8'd5,  8'd9,  8'd3,  8'd7,  8'd9));
        // short frame with gaps
        tbl.push_back(mk(0, 1, 8'd10, 0, 0, 0, 0, 0, 8'd10, 8'd0,  8'd0,  8'd0,  8'd10));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd10, 8'd0,  8'd0,  8'd0,  8'd10));
        tbl.push_back(mk(0, 1, 8'd20, 0, 0, 0, 0, 0, 8'd10, 8'd20, 8'd0,  8'd0,  8'd20));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 0, 0, 0, 8'd10, 8'd20, 8'd0,  8'd0,  8'd20));
        tbl.push_back(mk(0, 1, 8'd30, 0, 0, 0, 0, 0, 8'd10, 8'd20, 8'd30, 8'd0,  8'd30));
        tbl.push_back(mk(0, 0, 8'd0,  1, 0, 1, 1, 0, 8'd10, 8'd20, 8'd30, 8'd0,  8'd30));
        // overflow in HOLD, ack, new frame clears errors
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 1, 1, 1, 8'd10, 8'd20, 8'd30, 8'd0,  8'd30));
        tbl.push_back(mk(0, 0, 8'd0,  0, 0, 1, 1, 1, 8'd10, 8'd20, 8'd30, 8'd0,  8'd30));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 1, 1, 8'd10, 8'd20, 8'd30, 8'd0,  8'd30));
        tbl.push_back(mk(0, 1, 8'd1,  0, 0, 0, 0, 0, 8'd1,  8'd0,  8'd0,  8'd0,  8'd1));
        // last strobe together with pe_done is clean; overflow during ack cycle
        tbl.push_back(mk(0, 1, 8'd2,  0, 0, 0, 0, 0, 8'd1,  8'd2,  8'd0,  8'd0,  8'd2));
        tbl.push_back(mk(0, 1, 8'd3,  0, 0, 0, 0, 0, 8'd1,  8'd2,  8'd3,  8'd0,  8'd3));
        tbl.push_back(mk(0, 1, 8'h80, 1, 0, 1, 0, 0, 8'd1,  8'd2,  8'd3,  8'h80, 8'h80));
        tbl.push_back(mk(0, 1, 8'h11, 0, 1, 0, 0, 1, 8'd1,  8'd2,  8'd3,  8'h80, 8'h80));
        // reset mid-frame wins over a coincident strobe
        tbl.push_back(mk(0, 1, 8'h40, 0, 0, 0, 0, 0, 8'h40, 8'd0,  8'd0,  8'd0,  8'h40));
        tbl.push_back(mk(0, 1, 8'h50, 0, 0, 0, 0, 0, 8'h40, 8'h50, 8'd0,  8'd0,  8'h50));
        tbl.push_back(mk(1, 1, 8'h99, 0, 0, 0, 0, 0, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0));
        tbl.push_back(mk(0, 1, 8'd1,  0, 0, 0, 0, 0, 8'd1,  8'd0,  8'd0,  8'd0,  8'd1));
        tbl.push_back(mk(0, 1, 8'd2,  0, 0, 0, 0, 0, 8'd1,  8'd2,  8'd0,  8'd0,  8'd2));
        tbl.push_back(mk(0, 1, 8'd3,  0, 0, 0, 0, 0, 8'd1,  8'd2,  8'd3,  8'd0,  8'd3));
        tbl.push_back(mk(0, 1, 8'd4,  0, 0, 1, 0, 0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd4));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 0, 0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd4));
        // ack and pe_done in IDLE do nothing; ack ignored once a frame starts
        tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 0, 0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd4));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 0, 0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd4));
        tbl.push_back(mk(0, 1, 8'd6,  0, 1, 0, 0, 0, 8'd6,  8'd0,  8'd0,  8'd0,  8'd6));
        tbl.push_back(mk(0, 0, 8'd0,  1, 0, 1, 1, 0, 8'd6,  8'd0,  8'd0,  8'd0,  8'd6));
        // max is unsigned
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 1, 0, 8'd6,  8'd0,  8'd0,  8'd0,  8'd6));
        tbl.push_back(mk(0, 1, 8'hF0, 0, 0, 0, 0, 0, 8'hF0, 8'd0,  8'd0,  8'd0,  8'hF0));
        tbl.push_back(mk(0, 1, 8'h7F, 0, 0, 0, 0, 0, 8'hF0, 8'h7F, 8'd0,  8'd0,  8'hF0));
        tbl.push_back(mk(0, 0, 8'd0,  1, 0, 1, 1, 0, 8'hF0, 8'h7F, 8'd0,  8'd0,  8'hF0));
        tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 1, 0, 8'hF0, 8'h7F, 8'd0,  8'd0,  8'hF0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; en_result = tbl[i].en; acc_in = tbl[i].acc;
            pe_done = tbl[i].done; result_ack = tbl[i].ack;
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            chk_all($sformatf("vec%0d", i), e);
        end

        // random back-to-back burst: data pushed as driven, checked when valid shows
        reset = 1'b0; pe_done = 1'b0; result_ack = 1'b0;
        mx = 8'd0;
        for (int k = 0; k < 4; k++) begin
            en_result = 1'b1;
            acc_in = 8'($urandom_range(0, 255));
            data_q.push_back(acc_in);
            if (k == 0 || acc_in > mx) mx = acc_in;
            @(posedge clk); #1;
        end
        en_result = 1'b0;
        n = 0;
        while (!result_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("burst.valid_wait", 8'(n), 8'd0);
        chk("burst.c_1_1", c_1_1, data_q.pop_front());
        chk("burst.c_1_2", c_1_2, data_q.pop_front());
        chk("burst.c_2_1", c_2_1, data_q.pop_front());
        chk("burst.c_2_2", c_2_2, data_q.pop_front());
        chk("burst.max_out", max_out, mx);
        chk("burst.errs", {6'd0, err_short, err_overflow}, 8'd0);
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        chk("burst.ack_valid", {7'd0, result_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
